// File: rtl/pwm_pkg.sv
// Shared PWM definitions: mode encoding, nominal duty table and the duty
// classification thresholds used by both the LED PWM generator and decoder.
package pwm_pkg;

   localparam int MODE_W    = 3;
   localparam int MODE_MIN  = 0;
   localparam int MODE_MAX  = 5;
   localparam int NUM_MODES = MODE_MAX - MODE_MIN + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HIGH,
      ST_LOW,
      ST_STUCK_LO,
      ST_STUCK_HI,
      ST_LOW_UNARMED
   } dec_state_e;

   // Nominal duty per mode in per-mille.
   function automatic int duty_pm(input int m);
      case (m)
         0:       return 0;
         1:       return 50;
         2:       return 250;
         3:       return 500;
         4:       return 750;
         default: return 1000;
      endcase
   endfunction

   // Threshold between mode idx-1 and idx (idx = 1..5): midpoint of the two
   // nominal duties, scaled to the period and floored.
   function automatic int thr(input int period, input int idx);
      longint mid;
      mid = longint'((duty_pm(idx - 1) + duty_pm(idx)) / 2);
      return int'((longint'(period) * mid) / 1000);
   endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer plus one delay flop; reports the synchronized level
// and single-cycle rise/fall strobes.
module pwm_sync_edge (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic s1_q, s2_q, s3_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign level_o = s2_q;
   assign rise_o  = s2_q & ~s3_q;
   assign fall_o  = ~s2_q & s3_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Recovers the brightness mode from a sampled PWM waveform by measuring
// high time and period, with stuck-line detection after 2*PERIOD cycles.
module pwm_duty_decoder
   import pwm_pkg::*;
#(
   parameter int PERIOD     = 1_000_000,
   parameter int PERIOD_TOL = PERIOD / 8
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              pwm_in_i,
   output logic [MODE_W-1:0] mode_o,
   output logic              valid_o,
   output logic              mode_tick_o,
   output logic              period_err_o
);

   localparam int CNT_W = $clog2(2 * PERIOD + 1);

   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(2 * PERIOD);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] T1      = CNT_W'(thr(PERIOD, 1));
   localparam logic [CNT_W-1:0] T2      = CNT_W'(thr(PERIOD, 2));
   localparam logic [CNT_W-1:0] T3      = CNT_W'(thr(PERIOD, 3));
   localparam logic [CNT_W-1:0] T4      = CNT_W'(thr(PERIOD, 4));
   localparam logic [CNT_W-1:0] T5      = CNT_W'(thr(PERIOD, 5));
   localparam logic [CNT_W:0]   P_MIN   = (CNT_W + 1)'(PERIOD - PERIOD_TOL);
   localparam logic [CNT_W:0]   P_MAX   = (CNT_W + 1)'(PERIOD + PERIOD_TOL);

   function automatic logic [MODE_W-1:0] classify(input logic [CNT_W-1:0] h);
      if (h < T1)      return MODE_W'(0);
      else if (h < T2) return MODE_W'(1);
      else if (h < T3) return MODE_W'(2);
      else if (h < T4) return MODE_W'(3);
      else if (h < T5) return MODE_W'(4);
      else             return MODE_W'(5);
   endfunction

   logic level, rise, fall;

   pwm_sync_edge u_sync (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .d_i       (pwm_in_i),
      .level_o   (level),
      .rise_o    (rise),
      .fall_o    (fall)
   );

   dec_state_e        st_q, st_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  h_q, h_d;
   logic [MODE_W-1:0] mode_q, mode_d;
   logic              valid_q, valid_d;
   logic              tick_q, tick_d;
   logic              perr_q, perr_d;

   logic [CNT_W:0]    p_meas;
   logic              stuck, timeout, ld;
   logic [MODE_W-1:0] ld_mode;

   // In LOW, cnt_q holds the low-phase length up to (excluding) the rise cycle.
   assign p_meas  = {1'b0, h_q} + {1'b0, cnt_q};
   assign stuck   = (st_q == ST_STUCK_LO) || (st_q == ST_STUCK_HI);
   assign timeout = !stuck && !rise && !fall && (cnt_q == CNT_SAT);

   always_comb begin
      st_d    = st_q;
      cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
      h_d     = h_q;
      mode_d  = mode_q;
      valid_d = valid_q;
      perr_d  = perr_q;
      tick_d  = 1'b0;
      ld      = 1'b0;
      ld_mode = mode_q;

      // The edge cycle is the first cycle of the new level.
      if (rise || fall) cnt_d = CNT_ONE;

      case (st_q)
         ST_IDLE, ST_LOW_UNARMED, ST_STUCK_LO: begin
            if (rise) st_d = ST_HIGH;
         end
         ST_HIGH: begin
            if (fall) begin
               h_d  = cnt_q;
               st_d = ST_LOW;
            end
         end
         ST_LOW: begin
            if (rise) begin
               st_d = ST_HIGH;
               if (p_meas < P_MIN || p_meas > P_MAX) begin
                  perr_d = 1'b1;
               end else begin
                  perr_d  = 1'b0;
                  ld      = 1'b1;
                  ld_mode = classify(h_q);
               end
            end
         end
         ST_STUCK_HI: begin
            if (fall) st_d = ST_LOW_UNARMED;
         end
         default: st_d = ST_IDLE;
      endcase

      if (timeout) begin
         ld      = 1'b1;
         perr_d  = 1'b0;
         ld_mode = level ? MODE_W'(MODE_MAX) : MODE_W'(MODE_MIN);
         st_d    = level ? ST_STUCK_HI : ST_STUCK_LO;
      end

      if (ld) begin
         mode_d  = ld_mode;
         valid_d = 1'b1;
         tick_d  = (ld_mode != mode_q) || !valid_q;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         st_q    <= ST_IDLE;
         cnt_q   <= '0;
         h_q     <= '0;
         mode_q  <= '0;
         valid_q <= 1'b0;
         tick_q  <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         h_q     <= h_d;
         mode_q  <= mode_d;
         valid_q <= valid_d;
         tick_q  <= tick_d;
         perr_q  <= perr_d;
      end
   end

   assign mode_o       = mode_q;
   assign valid_o      = valid_q;
   assign mode_tick_o  = tick_q;
   assign period_err_o = perr_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder at PERIOD=200 (T = 5/30/75/125/175).
module tb_pwm_duty_decoder;

   typedef struct {
      int hi;
      int per;
      int mode;
      int valid;
      int perr;
      int tick;
   } vec_t;

   logic       clk_i = 1'b0;
   logic       reset_n_i;
   logic       pwm_in_i;
   logic [2:0] mode_o;
   logic       valid_o;
   logic       mode_tick_o;
   logic       period_err_o;

   int   checks   = 0;
   int   fails    = 0;
   int   tick_cnt = 0;
   logic prev_tick = 1'b0;

   always #5 clk_i = ~clk_i;

   pwm_duty_decoder #(.PERIOD(200)) dut (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .pwm_in_i     (pwm_in_i),
      .mode_o       (mode_o),
      .valid_o      (valid_o),
      .mode_tick_o  (mode_tick_o),
      .period_err_o (period_err_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   always @(negedge clk_i) begin
      if (mode_tick_o === 1'b1) begin
         tick_cnt++;
         chk("tick_back_to_back", {31'b0, prev_tick}, 32'd0);
      end
      prev_tick = mode_tick_o;
   end

   task automatic hold(input logic lvl, input int n);
      repeat (n) begin
         @(negedge clk_i);
         pwm_in_i = lvl;
      end
   endtask

   // One PWM period starting with a rise. The rise completes the previous
   // period: outputs must still show pm/pv/pp two edges in, and nm/nv/np/nt
   // three edges in; the tick must be gone one cycle later.
   task automatic apply_period(input int hi, input int per,
                               input int pm, input int pv, input int pp,
                               input int nm, input int nv, input int np, input int nt);
      for (int c = 0; c < per; c++) begin
         @(negedge clk_i);
         if (c == 2) begin
            chk("pre_mode", mode_o, pm);
            chk("pre_valid", valid_o, pv);
            chk("pre_perr", period_err_o, pp);
            chk("pre_tick", mode_tick_o, 0);
         end
         if (c == 3) begin
            chk("mode", mode_o, nm);
            chk("valid", valid_o, nv);
            chk("period_err", period_err_o, np);
            chk("mode_tick", mode_tick_o, nt);
         end
         if (c == 4) chk("tick_clear", mode_tick_o, 0);
         pwm_in_i = (c < hi);
      end
   endtask

   initial begin
      vec_t vt[19];
      int pm, pv, pp, nm, nv, np, nt, t0;

      // hi, period, then outputs expected once this period completes
      vt = '{
         '{100, 200, 3, 1, 0, 1},
         '{100, 200, 3, 1, 0, 0},
         '{ 10, 200, 1, 1, 0, 1},
         '{ 50, 200, 2, 1, 0, 1},
         '{150, 200, 4, 1, 0, 1},
         '{120, 240, 4, 1, 1, 0},
         '{150, 200, 4, 1, 0, 0},
         '{ 29, 200, 1, 1, 0, 1},
         '{ 30, 200, 2, 1, 0, 1},
         '{175, 200, 5, 1, 0, 1},
         '{174, 200, 4, 1, 0, 1},
         '{  4, 200, 0, 1, 0, 1},
         '{  5, 200, 1, 1, 0, 1},
         '{100, 225, 3, 1, 0, 1},
         '{ 10, 226, 3, 1, 1, 0},
         '{150, 175, 4, 1, 0, 1},
         '{ 30, 174, 4, 1, 1, 0},
         '{ 75, 200, 3, 1, 0, 1},
         '{125, 200, 4, 1, 0, 1}
      };

      reset_n_i = 1'b0;
      pwm_in_i  = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("rst_mode", mode_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_tick", mode_tick_o, 0);
      chk("rst_perr", period_err_o, 0);
      reset_n_i = 1'b1;

      // First rise from IDLE reports nothing.
      pm = 0; pv = 0; pp = 0;
      nm = 0; nv = 0; np = 0; nt = 0;
      foreach (vt[i]) begin
         apply_period(vt[i].hi, vt[i].per, pm, pv, pp, nm, nv, np, nt);
         pm = nm; pv = nv; pp = np;
         nm = vt[i].mode; nv = vt[i].valid; np = vt[i].perr; nt = vt[i].tick;
      end
      apply_period(100, 200, pm, pv, pp, nm, nv, np, nt);

      // Async reset in the middle of a high phase (mode is 3 here).
      hold(1'b1, 50);
      #2;
      reset_n_i = 1'b0;
      pwm_in_i  = 1'b0;
      #1;
      chk("async_rst_mode", mode_o, 0);
      chk("async_rst_valid", valid_o, 0);
      chk("async_rst_tick", mode_tick_o, 0);
      chk("async_rst_perr", period_err_o, 0);
      hold(1'b0, 3);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      hold(1'b0, 60);
      apply_period(100, 200, 0, 0, 0, 0, 0, 0, 0);
      apply_period(100, 200, 0, 0, 0, 3, 1, 0, 1);

      // Stuck low from reset: decode lands on the 401st edge after release.
      @(negedge clk_i);
      reset_n_i = 1'b0;
      pwm_in_i  = 1'b0;
      hold(1'b0, 2);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      t0 = tick_cnt;
      repeat (400) @(negedge clk_i);
      chk("stuck_lo_early_valid", valid_o, 0);
      @(negedge clk_i);
      chk("stuck_lo_valid", valid_o, 1);
      chk("stuck_lo_mode", mode_o, 0);
      chk("stuck_lo_tick", mode_tick_o, 1);
      hold(1'b0, 400);
      chk("stuck_lo_one_tick", tick_cnt - t0, 1);

      // Stuck high.
      hold(1'b1, 410);
      chk("stuck_hi_mode", mode_o, 5);
      chk("stuck_hi_valid", valid_o, 1);
      chk("stuck_hi_perr", period_err_o, 0);
      hold(1'b1, 400);
      chk("stuck_hi_one_tick", tick_cnt - t0, 2);

      // Leaving stuck-high: the partial low phase is not measured.
      hold(1'b0, 50);
      apply_period(100, 200, 5, 1, 0, 5, 1, 0, 0);
      apply_period(100, 200, 5, 1, 0, 3, 1, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
- Receive-side counterpart of the LED PWM generator: samples a PWM waveform on one pin and recovers the 3-bit brightness mode (0..5) that produced it.
- Used for loop-back checking of the LED driver and for brightness commands from an external board.
- Measures high time and period in clk cycles, then classifies the duty against the team duty table.

Parameters:
- PERIOD, 1_000_000, nominal PWM period in clk cycles (100 Hz at 100 MHz); sim uses 200.
- PERIOD_TOL, PERIOD/8, allowed |measured period - PERIOD| in cycles.
- CNT_W, $clog2(2*PERIOD+1), counter width (derived, do not override).

Ports:
- clk  input  1  system clock, 100 MHz
- reset_n  input  1  reset, asynchronous, active-low
- pwm_in  input  1  asynchronous PWM waveform
- mode  output  3  decoded brightness mode, 0..5
- valid  output  1  high once at least one decode (measured or stuck) has completed
- mode_tick  output  1  one-cycle pulse when mode changes or valid first rises
- period_err  output  1  last completed period was outside PERIOD±PERIOD_TOL

Behaviour:
- Reset (async assert, sync-safe deassert): mode=0, valid=0, mode_tick=0, period_err=0, sync flops=0, state IDLE, counter=0.
- Input path: two-flop synchronizer s1,s2 plus delay flop s3. rise = s2&~s3. fall = ~s2&s3.
- All outputs are registered. They update on the clk edge where rise or timeout is true, i.e. 3 edges after pwm_in is first sampled at the new level.
- h = number of cycles s2 was 1 in the last pulse. p = h + cycles s2 was 0 until the next rise. For synchronous stimulus both are exact.
- Counter saturates at 2*PERIOD and never wraps.

States:
- IDLE: wait for rise, then go to HIGH. No measurement is reported from this partial period.
- HIGH: count. On fall, latch h and go to LOW.
- LOW: count. On rise, complete the measurement (p = h + low count), then go to HIGH.
- STUCK_LO / STUCK_HI: wait for the next edge. Rise from STUCK_LO goes to HIGH. Fall from STUCK_HI goes to LOW_UNARMED (behaves as IDLE waiting for rise).

Timeout:
- In any state, if the cycles since the last edge reach 2*PERIOD: s2=0 gives mode=0 and STUCK_LO; s2=1 gives mode=5 and STUCK_HI.
- valid=1 and period_err=0.
- Only one timeout decode per stuck episode.

Completed measurement:
- If |p-PERIOD|>PERIOD_TOL: period_err=1, mode held, no tick.
- Otherwise: period_err=0, valid=1, and mode is classified by h against thresholds T1..T5 = PERIOD*{25,150,375,625,875}/1000 (integer floor):
  - h<T1 → 0
  - h<T2 → 1
  - h<T3 → 2
  - h<T4 → 3
  - h<T5 → 4
  - else → 5
- Nominal duties are 0/5/25/50/75/100 %. Thresholds are the midpoints.

Other rules:
- mode_tick: asserted on the cycle after mode/valid load when the new mode differs from the old one, or valid goes 0→1. Otherwise 0. Never high two cycles in a row.
- Edge and timeout in the same cycle: the edge wins and the counter restarts.
- Glitches shorter than 1 cycle are filtered only by sampling; no extra debounce.
- Reset mid-measurement discards all partial counts.

Decomposition:
- Shared package pwm_pkg:
  - mode encoding constants MODE_MIN=0, MODE_MAX=5, mode width 3.
  - nominal duty table (per-mille: 0,50,250,500,750,1000).
  - threshold function thr(period,idx), used by both the generator and this decoder.
- Sub-module pwm_sync_edge: 2-flop synchronizer + delay flop, with async active-low reset. Outputs level, rise, fall.
- The FSM, counter and classifier stay in pwm_duty_decoder.

Test Plan (PERIOD=200, PERIOD_TOL=25, T=5/30/75/125/175):
- 100 cycles high / 100 low, repeated: after the 2nd rise (+3 edges) mode=3, valid=1, mode_tick single pulse, period_err=0; no further ticks on later periods.
- Step the duty 10→50→150 cycles high (period 200): mode goes 1→2→4, one mode_tick per change, each update 3 edges after the completing rise.
- pwm_in held low 400+ cycles from reset: mode=0, valid=1, tick once; then held high ≥400 cycles: mode=5, tick once.
- Period 240 with 120 high: period_err=1, mode keeps its previous value, no tick. Next 200-cycle period with 150 high: period_err=0, mode=4.
- Boundary h=29 vs h=30 at period 200: mode=1 then mode=2. h=175 gives mode=5.
- Assert reset_n low mid-HIGH: all outputs 0 immediately (async). After release, first valid only after one complete period.
